// File: rtl/wormhole_switch_allocator_pkg.sv
// Shared types and helpers for the single-VC wormhole switch allocator.
package wormhole_switch_allocator_pkg;

  localparam int PORT_NUM  = 5;
  localparam int PORT_SIZE = 3;

  typedef enum logic [PORT_SIZE-1:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic {
    ALLOC_IDLE,
    ALLOC_LOCKED
  } alloc_state_t;

  function automatic logic is_head(input flit_label_t lab);
    return (lab == HEAD) || (lab == HEADTAIL);
  endfunction

  function automatic logic [PORT_SIZE-1:0] next_ptr(input logic [PORT_SIZE-1:0] p);
    return (p >= PORT_SIZE'(PORT_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/wormhole_switch_allocator_if.sv
// Request/grant bundle between the input buffers, the allocator and the crossbar.
interface wormhole_switch_allocator_if;
  import wormhole_switch_allocator_pkg::*;

  logic [PORT_NUM-1:0]                req_valid_i;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] req_port_i;
  logic [PORT_NUM-1:0][1:0]           req_label_i;
  logic [PORT_NUM-1:0]                out_ready_i;
  logic [PORT_NUM-1:0]                grant_o;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] xbar_sel_o;
  logic [PORT_NUM-1:0]                xbar_valid_o;
  logic [PORT_NUM-1:0]                lock_o;
  logic                               proto_err_o;

  modport master (
    output req_valid_i, req_port_i, req_label_i, out_ready_i,
    input  grant_o, xbar_sel_o, xbar_valid_o, lock_o, proto_err_o
  );

  modport slave (
    input  req_valid_i, req_port_i, req_label_i, out_ready_i,
    output grant_o, xbar_sel_o, xbar_valid_o, lock_o, proto_err_o
  );

endinterface

// File: rtl/wormhole_switch_allocator_rr_arbiter.sv
// Combinational round-robin search: first request at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                        = 1'b1;
        gnt[(int'(ptr) + k) % N]   = 1'b1;
        idx                        = W'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Per-output wormhole allocation: round-robin on head flits, locked to the owner until its tail.
//   state        | meaning
//   ALLOC_IDLE   | output free; arbitrate HEAD/HEADTAIL requests from rr_ptr
//   ALLOC_LOCKED | output held by owner until its TAIL is granted
module wormhole_switch_allocator
  import wormhole_switch_allocator_pkg::*;
(
  input logic                        clk,
  input logic                        rst_n,
  wormhole_switch_allocator_if.slave bus
);

  alloc_state_t [PORT_NUM-1:0]        state;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] owner;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] rr_ptr;
  logic                               proto_err_q;

  // request matrices are indexed [output][input]
  logic [PORT_NUM-1:0][PORT_NUM-1:0]  tgt, cand, arb_gnt, out_gnt;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] arb_idx, out_idx;
  logic [PORT_NUM-1:0]                arb_any, out_valid, out_err;
  logic [PORT_NUM-1:0]                malformed, head_mask, lock, grant;

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      malformed[i] = bus.req_valid_i[i] && (bus.req_port_i[i] >= PORT_SIZE'(PORT_NUM));
      head_mask[i] = is_head(flit_label_t'(bus.req_label_i[i]));
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        tgt[o][i]  = bus.req_valid_i[i] && (bus.req_port_i[i] == PORT_SIZE'(o));
        cand[o][i] = tgt[o][i] && head_mask[i];
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    rr_arbiter #(.N(PORT_NUM), .W(PORT_SIZE)) u_arb (
      .req (cand[o]),
      .ptr (rr_ptr[o]),
      .gnt (arb_gnt[o]),
      .idx (arb_idx[o]),
      .any (arb_any[o])
    );
  end

  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      out_gnt[o]   = '0;
      out_valid[o] = 1'b0;
      out_idx[o]   = '0;
      out_err[o]   = 1'b0;
      if (state[o] == ALLOC_IDLE) begin
        out_valid[o] = arb_any[o] && bus.out_ready_i[o];
        out_idx[o]   = arb_idx[o];
        out_gnt[o]   = arb_gnt[o];
        out_err[o]   = |(tgt[o] & ~head_mask);
      end else begin
        out_valid[o] = tgt[o][owner[o]] && !head_mask[owner[o]] && bus.out_ready_i[o];
        out_idx[o]   = owner[o];
        out_gnt[o]   = PORT_NUM'(1) << owner[o];
        out_err[o]   = tgt[o][owner[o]] && head_mask[owner[o]];
      end
      if (!out_valid[o]) begin
        out_gnt[o] = '0;
        out_idx[o] = '0;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      grant = grant | out_gnt[o];
      lock[o] = (state[o] == ALLOC_LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < PORT_NUM; o++) state[o] <= ALLOC_IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= (|out_err) || (|malformed);
      for (int o = 0; o < PORT_NUM; o++) begin
        if (out_valid[o]) begin
          if (state[o] == ALLOC_IDLE) begin
            rr_ptr[o] <= next_ptr(out_idx[o]);
            if (flit_label_t'(bus.req_label_i[out_idx[o]]) == HEAD) begin
              state[o] <= ALLOC_LOCKED;
              owner[o] <= out_idx[o];
            end
          end else if (flit_label_t'(bus.req_label_i[owner[o]]) == TAIL) begin
            // the tail releases at this edge; waiting heads arbitrate next cycle
            state[o] <= ALLOC_IDLE;
          end
        end
      end
    end
  end

  assign bus.grant_o      = grant;
  assign bus.xbar_sel_o   = out_idx;
  assign bus.xbar_valid_o = out_valid;
  assign bus.lock_o       = lock;
  assign bus.proto_err_o  = proto_err_q;

endmodule

// File: doc/wormhole_switch_allocator.md
Name: wormhole_switch_allocator

Overview:
- Per-router switch allocator for the 5-port mesh router with a single VC (wormhole switching).
- Each input port requests one output port for the flit at the head of its buffer. Each output is shared among the inputs by round-robin arbitration on HEAD/HEADTAIL flits.
- An output stays locked to the winning input until that packet's TAIL passes.
- The block drives the input-buffer pops (grant_o) and the crossbar selects.

Parameters:
PORT_NUM, noc_params::PORT_NUM (5), number of input and output ports
PORT_SIZE, noc_params::PORT_SIZE (3), width of a port index

Ports:
clk  input  1  router clock
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  PORT_NUM  input i has a flit at its buffer head
req_port_i  input  PORT_NUM x PORT_SIZE  output requested by input i (port_t encoding, from route compute)
req_label_i  input  PORT_NUM x 2  flit_label_t of input i's head flit
out_ready_i  input  PORT_NUM  output o can accept a flit this cycle (downstream credit available)
grant_o  output  PORT_NUM  input i's flit traverses the switch this cycle; pop its buffer
xbar_sel_o  output  PORT_NUM x PORT_SIZE  input index driven onto output o
xbar_valid_o  output  PORT_NUM  output o carries a valid flit this cycle
lock_o  output  PORT_NUM  output o is held by an in-flight packet (status)
proto_err_o  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset: all outputs are ALLOC_IDLE with owner 0 and rr_ptr 0 (LOCAL). lock_o=0 and proto_err_o=0. Reset is asynchronous and abandons any packet in flight.
- All grant/xbar outputs are combinational from registered state plus the current inputs, so there is zero-cycle latency from request to grant.
- State (lock, owner, rr_ptr) updates only on the rising edge of clk.
- A request is well-formed only when req_port_i < PORT_NUM. A request with port 5..7 is never granted and raises proto_err_o.
- Output in ALLOC_IDLE:
  - Eligible candidates are inputs with valid, well-formed requests to this output and label HEAD or HEADTAIL.
  - The winner is the first eligible input at or after rr_ptr, searching with wrap-around (index 4 wraps to 0).
  - A grant requires out_ready_i[o]=1. With no ready, there is no grant and no state change; the winner is re-arbitrated next cycle.
  - On a grant: rr_ptr <= (winner+1) mod PORT_NUM.
  - If the granted label is HEAD: state <= ALLOC_LOCKED, owner <= winner.
  - If the granted label is HEADTAIL: stay ALLOC_IDLE.
- Output in ALLOC_LOCKED:
  - Only the owner is considered. It is granted when req_valid_i[owner]=1, it targets this output, and out_ready_i[o]=1.
  - A granted TAIL returns the output to ALLOC_IDLE. rr_ptr does not change.
  - A granted BODY keeps the lock.
  - The owner's valid stalling (bubble) holds the lock.
- Protocol errors (each pulses proto_err_o; the offending request is not granted):
  - a BODY/TAIL request to an IDLE output;
  - a HEAD/HEADTAIL request from an owner to the output it already holds.
- Other inputs requesting a locked output wait with no error.
- Conflict-free by construction: each input names one output, so grant_o has at most one source per input and xbar_sel_o has at most one input per output.
- A simultaneous TAIL grant and a new HEAD request to the same output: the new HEAD is arbitrated only in the next cycle (the lock is released at the edge).
- lock_o[o] = (state==ALLOC_LOCKED).
- xbar_sel_o is 0 when xbar_valid_o=0.

Decomposition:
- noc_params additions:
  - typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_t;
  - reuse port_t, flit_label_t, PORT_NUM, PORT_SIZE.
- Sub-module rr_arbiter:
  - N-request combinational priority search from a ptr input;
  - outputs a one-hot grant and the winner index;
  - one instance per output port.
- Allocator top holds the per-output state registers and the input-to-output request matrix.

Test Plan:
- Reset, then input 1 sends HEADTAIL to EAST(4) with ready=1 -> grant_o=00010, xbar_sel_o[4]=1, xbar_valid_o[4]=1; lock_o[4] stays 0; rr_ptr[4] becomes 2.
- Inputs 0 and 2 both send HEAD to NORTH(1) with rr_ptr=0:
  - input 0 is granted and lock_o[1]=1;
  - the next cycle input 0 sends BODY while input 2 keeps its HEAD -> only input 0 is granted.
- Input 0 then sends TAIL -> it is granted and lock_o[1] drops. The next cycle input 2's HEAD is granted (rr_ptr=1).
- Locked WEST(3), owner 3, out_ready_i[3]=0 for 3 cycles with BODY pending -> no grant, lock held. On ready=1 -> BODY granted.
- Input 4 sends BODY to IDLE SOUTH(2) -> no grant, proto_err_o pulses 1 cycle. Also: req_port_i=6 -> no grant, proto_err_o=1.
- Assert rst_n=0 mid-packet while output 1 is locked -> lock_o=0 asynchronously. After release, a fresh HEAD from input 3 to output 1 is granted.
